// File: rtl/tl_ul_pkg.sv
// +--------------------------------------------------------------------------+
// | tl_ul_pkg: TL-UL opcodes, A-beat payload type and buffer defaults        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package tl_ul_pkg;

  localparam int TL_ADDR_W               = 32;
  localparam int TL_SOURCE_W             = 1;
  localparam int TL_DEPTH_DEFAULT        = 2;
  localparam int TL_MAX_INFLIGHT_DEFAULT = 4;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [1:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
    logic [3:0]             mask;
    logic [31:0]            data;
  } tl_a_beat_t;

endpackage

`default_nettype wire

// File: rtl/tl_ul_fifo.sv
// +--------------------------------------------------------------------------+
// | tl_ul_fifo: generic packed-payload FIFO, registered head, no bypass      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tl_ul_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_ul_a_buffer.sv
// +--------------------------------------------------------------------------+
// | tl_ul_a_buffer: TL-UL A-channel buffer with outstanding-request limiter; |
// | optional stall statistics under TL_ABUF_STALL_STATS_EN.  rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tl_ul_a_buffer
  import tl_ul_pkg::*;
#(
  parameter int DEPTH        = TL_DEPTH_DEFAULT,
  parameter int MAX_INFLIGHT = TL_MAX_INFLIGHT_DEFAULT,
  parameter int ADDR_W       = TL_ADDR_W,
  parameter int SOURCE_W     = TL_SOURCE_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_param,
  input  logic [1:0]          in_a_size,
  input  logic [SOURCE_W-1:0] in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [3:0]          in_a_mask,
  input  logic [31:0]         in_a_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_param,
  output logic [1:0]          out_a_size,
  output logic [SOURCE_W-1:0] out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [3:0]          out_a_mask,
  output logic [31:0]         out_a_data,
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_opcode,
  input  logic [1:0]          out_d_param,
  input  logic [1:0]          out_d_size,
  input  logic [SOURCE_W-1:0] out_d_source,
  input  logic                out_d_denied,
  input  logic [31:0]         out_d_data,
  output logic                in_d_valid,
  input  logic                in_d_ready,
  output logic [2:0]          in_d_opcode,
  output logic [1:0]          in_d_param,
  output logic [1:0]          in_d_size,
  output logic [SOURCE_W-1:0] in_d_source,
  output logic                in_d_denied,
  output logic [31:0]         in_d_data,
  output logic [3:0]          inflight,
  output logic [15:0]         stall_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  tl_a_beat_t in_beat, head_beat;
  logic       fifo_empty, fifo_full, fifo_ready;
  logic       a_fire, d_fire;
  logic [3:0] inflight_q, inflight_d;

  assign in_beat = '{opcode:  in_a_opcode,
                     param:   in_a_param,
                     size:    in_a_size,
                     source:  in_a_source,
                     address: in_a_address,
                     mask:    in_a_mask,
                     data:    in_a_data};

  tl_ul_fifo #(
    .T     (tl_a_beat_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (in_a_valid),
    .push_ready (fifo_ready),
    .push_data  (in_beat),
    .pop        (a_fire),
    .head       (head_beat),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Ready comes straight from the registered full flag; a same-cycle pop
  // never reopens the input.
  assign in_a_ready = fifo_ready;

  assign out_a_valid   = !fifo_empty && (inflight_q < MAX_CNT);
  assign out_a_opcode  = head_beat.opcode;
  assign out_a_param   = head_beat.param;
  assign out_a_size    = head_beat.size;
  assign out_a_source  = head_beat.source;
  assign out_a_address = head_beat.address;
  assign out_a_mask    = head_beat.mask;
  assign out_a_data    = head_beat.data;

  assign in_d_valid  = out_d_valid;
  assign in_d_opcode = out_d_opcode;
  assign in_d_param  = out_d_param;
  assign in_d_size   = out_d_size;
  assign in_d_source = out_d_source;
  assign in_d_denied = out_d_denied;
  assign in_d_data   = out_d_data;
  assign out_d_ready = in_d_ready;

  assign a_fire   = out_a_valid && out_a_ready;
  assign d_fire   = out_d_valid && in_d_ready;
  assign inflight = inflight_q;

  // An unmatched D beat at zero leaves the count pinned rather than wrapping.
  always_comb begin
    inflight_d = inflight_q;
    if (a_fire && !d_fire) begin
      inflight_d = inflight_q + 4'd1;
    end else if (d_fire && !a_fire && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 4'd0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

`ifdef TL_ABUF_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fifo_empty && (inflight_q == MAX_CNT) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (d_fire && (inflight_q == 4'd0)) begin
      $display("tl_ul_a_buffer: D without A");
    end
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_tl_ul_a_buffer.sv
// +--------------------------------------------------------------------------+
// | tb_tl_ul_a_buffer: queue-model checker with directed and random traffic  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tl_ul_a_buffer;
  import tl_ul_pkg::*;

  localparam int DEPTH        = 2;
  localparam int MAX_INFLIGHT = 4;
  localparam int ADDR_W       = 32;
  localparam int SOURCE_W     = 1;

  logic                clock   = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_a_valid, in_a_ready;
  logic [2:0]          in_a_opcode, in_a_param;
  logic [1:0]          in_a_size;
  logic [SOURCE_W-1:0] in_a_source;
  logic [ADDR_W-1:0]   in_a_address;
  logic [3:0]          in_a_mask;
  logic [31:0]         in_a_data;
  logic                out_a_valid, out_a_ready;
  logic [2:0]          out_a_opcode, out_a_param;
  logic [1:0]          out_a_size;
  logic [SOURCE_W-1:0] out_a_source;
  logic [ADDR_W-1:0]   out_a_address;
  logic [3:0]          out_a_mask;
  logic [31:0]         out_a_data;
  logic                out_d_valid, out_d_ready;
  logic [2:0]          out_d_opcode;
  logic [1:0]          out_d_param, out_d_size;
  logic [SOURCE_W-1:0] out_d_source;
  logic                out_d_denied;
  logic [31:0]         out_d_data;
  logic                in_d_valid, in_d_ready;
  logic [2:0]          in_d_opcode;
  logic [1:0]          in_d_param, in_d_size;
  logic [SOURCE_W-1:0] in_d_source;
  logic                in_d_denied;
  logic [31:0]         in_d_data;
  logic [3:0]          inflight;
  logic [15:0]         stall_cnt;

  int checks = 0;
  int errors = 0;
  int n_afire_obs = 0;

  tl_a_beat_t q[$];
  int         m_inf   = 0;
  int         m_stall = 0;

  always #5 clock = ~clock;

  tl_ul_a_buffer #(
    .DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_denied(in_d_denied), .in_d_data(in_d_data),
    .inflight(inflight), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_stall();
`ifdef TL_ABUF_STALL_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // Reference model: a bounded queue plus an outstanding counter.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_inf   = 0;
      m_stall = 0;
    end else begin
      bit v, r, af, df;
      tl_a_beat_t b;
      v  = (q.size() > 0) && (m_inf < MAX_INFLIGHT);
      r  = q.size() < DEPTH;
      af = v && out_a_ready;
      df = out_d_valid && in_d_ready;
      if ((q.size() > 0) && (m_inf == MAX_INFLIGHT) && (m_stall < 65535)) m_stall++;
      if (af) void'(q.pop_front());
      if (in_a_valid && r) begin
        b = '{opcode: in_a_opcode, param: in_a_param, size: in_a_size, source: in_a_source,
              address: in_a_address, mask: in_a_mask, data: in_a_data};
        q.push_back(b);
      end
      if (af && !df) m_inf++;
      else if (df && !af && (m_inf > 0)) m_inf--;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      bit ev;
      ev = (q.size() > 0) && (m_inf < MAX_INFLIGHT);
      chk("in_a_ready", 96'(in_a_ready), 96'(q.size() < DEPTH));
      chk("out_a_valid", 96'(out_a_valid), 96'(ev));
      chk("inflight", 96'(inflight), 96'(m_inf));
      chk("stall_cnt", 96'(stall_cnt), 96'(exp_stall()));
      if (ev) begin
        chk("out_a_payload",
            96'({out_a_opcode, out_a_param, out_a_size, out_a_source,
                 out_a_address, out_a_mask, out_a_data}), 96'(q[0]));
      end
      chk("d_passthru",
          96'({in_d_valid, in_d_opcode, in_d_param, in_d_size, in_d_source,
               in_d_denied, in_d_data, out_d_ready}),
          96'({out_d_valid, out_d_opcode, out_d_param, out_d_size, out_d_source,
               out_d_denied, out_d_data, in_d_ready}));
      if (out_a_valid && out_a_ready) n_afire_obs++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_a_valid   = 1'b0;
    in_a_opcode  = '0;
    in_a_param   = '0;
    in_a_size    = '0;
    in_a_source  = '0;
    in_a_address = '0;
    in_a_mask    = '0;
    in_a_data    = '0;
    out_a_ready  = 1'b0;
    out_d_valid  = 1'b0;
    out_d_opcode = '0;
    out_d_param  = '0;
    out_d_size   = '0;
    out_d_source = '0;
    out_d_denied = 1'b0;
    out_d_data   = '0;
    in_d_ready   = 1'b1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    in_a_valid   = 1'b1;
    in_a_opcode  = op;
    in_a_param   = 3'd0;
    in_a_size    = 2'd2;
    in_a_source  = '0;
    in_a_address = addr;
    in_a_mask    = 4'hF;
    in_a_data    = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_wait();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = in_a_ready;
      tick();
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: got in_a_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0;
    idle();

    // Single Get and its AccessAckData.
    do_reset();
    chk("rst_inflight", 96'(inflight), 96'd0);
    chk("rst_in_a_ready", 96'(in_a_ready), 96'd1);
    chk("rst_out_a_valid", 96'(out_a_valid), 96'd0);
    chk("rst_stall_cnt", 96'(stall_cnt), 96'd0);
    set_a(Get, 32'h8000_0000, 32'h0);
    out_a_ready = 1'b1;
    #1 chk("no_bypass", 96'(out_a_valid), 96'd0);
    tick();
    in_a_valid = 1'b0;
    #1;
    chk("get_valid", 96'(out_a_valid), 96'd1);
    chk("get_addr", 96'(out_a_address), 96'h8000_0000);
    chk("get_opcode", 96'(out_a_opcode), 96'd4);
    tick();
    chk("get_inflight1", 96'(inflight), 96'd1);
    out_d_valid  = 1'b1;
    out_d_opcode = AccessAckData;
    out_d_data   = 32'hCAFE_F00D;
    #1 chk("d_data", 96'(in_d_data), 96'hCAFE_F00D);
    tick();
    out_d_valid = 1'b0;
    chk("get_inflight0", 96'(inflight), 96'd0);

    // Backpressure: third beat refused while full, order preserved.
    do_reset();
    set_a(PutFullData, 32'h100, 32'h1111_1111);
    tick();
    set_a(PutFullData, 32'h104, 32'h2222_2222);
    tick();
    set_a(PutFullData, 32'h108, 32'h3333_3333);
    #1 chk("full_ready", 96'(in_a_ready), 96'd0);
    tick();
    chk("full_ready2", 96'(in_a_ready), 96'd0);
    out_a_ready = 1'b1;
    #1 chk("order1", 96'(out_a_address), 96'h100);
    tick();
    chk("pop_full_refuses", 96'(out_a_address), 96'h104);
    tick();
    in_a_valid = 1'b0;
    #1;
    chk("order3_addr", 96'(out_a_address), 96'h108);
    chk("order3_data", 96'(out_a_data), 96'h3333_3333);
    tick();
    out_a_ready = 1'b0;

    // Limiter: six Puts with D held off.
    do_reset();
    out_a_ready = 1'b1;
    base = n_afire_obs;
    for (int i = 0; i < 6; i++) begin
      set_a(PutFullData, 32'h200 + 32'(4 * i), 32'(i));
      push_wait();
    end
    in_a_valid = 1'b0;
    repeat (4) tick();
    chk("lim_inflight", 96'(inflight), 96'd4);
    chk("lim_valid", 96'(out_a_valid), 96'd0);
    chk("lim_afires", 96'(n_afire_obs - base), 96'd4);
    out_d_valid = 1'b1;
    #1 chk("lim_dcycle_valid", 96'(out_a_valid), 96'd0);
    tick();
    out_d_valid = 1'b0;
    #1;
    chk("lim_after_d_inflight", 96'(inflight), 96'd3);
    chk("lim_after_d_valid", 96'(out_a_valid), 96'd1);
    tick();
    chk("lim_refill", 96'(inflight), 96'd4);
    s0 = int'(stall_cnt);
    repeat (10) tick();
`ifdef TL_ABUF_STALL_STATS_EN
    chk("stall_10", 96'(stall_cnt), 96'(s0 + 10));
`else
    chk("stall_tied", 96'(stall_cnt), 96'(s0 * 0));
`endif

    // Simultaneous a_fire and d_fire at inflight 2.
    do_reset();
    out_a_ready = 1'b1;
    set_a(PutFullData, 32'h300, 32'hA);
    tick();
    set_a(PutFullData, 32'h304, 32'hB);
    tick();
    in_a_valid = 1'b0;
    tick();
    chk("sim_pre", 96'(inflight), 96'd2);
    out_a_ready = 1'b0;
    set_a(Get, 32'h308, 32'h0);
    tick();
    in_a_valid  = 1'b0;
    out_a_ready = 1'b1;
    out_d_valid = 1'b1;
    #1 chk("sim_valid", 96'(out_a_valid), 96'd1);
    tick();
    out_d_valid = 1'b0;
    chk("sim_hold", 96'(inflight), 96'd2);

    // Spurious D at zero.
    do_reset();
    out_d_valid = 1'b1;
    tick();
    out_d_valid = 1'b0;
    chk("spurious_d", 96'(inflight), 96'd0);

    // Asynchronous reset mid-burst with a full FIFO and three outstanding.
    do_reset();
    out_a_ready = 1'b1;
    set_a(PutFullData, 32'h400, 32'h1);
    tick();
    set_a(PutFullData, 32'h404, 32'h2);
    tick();
    set_a(PutFullData, 32'h408, 32'h3);
    tick();
    in_a_valid = 1'b0;
    tick();
    out_a_ready = 1'b0;
    set_a(PutFullData, 32'h40C, 32'h4);
    tick();
    set_a(PutFullData, 32'h410, 32'h5);
    tick();
    in_a_valid = 1'b0;
    chk("mid_inflight", 96'(inflight), 96'd3);
    chk("mid_full", 96'(in_a_ready), 96'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 96'(out_a_valid), 96'd0);
    chk("arst_inflight", 96'(inflight), 96'd0);
    chk("arst_ready", 96'(in_a_ready), 96'd1);
    chk("arst_stall", 96'(stall_cnt), 96'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      in_a_valid   = 1'($urandom_range(0, 1));
      in_a_opcode  = 3'($urandom_range(0, 7));
      in_a_param   = 3'($urandom_range(0, 7));
      in_a_size    = 2'($urandom_range(0, 3));
      in_a_source  = SOURCE_W'($urandom_range(0, 1));
      in_a_address = $urandom;
      in_a_mask    = 4'($urandom_range(0, 15));
      in_a_data    = $urandom;
      out_a_ready  = ($urandom_range(0, 3) != 0);
      out_d_valid  = (m_inf > 0) && ($urandom_range(0, 2) == 0);
      in_d_ready   = ($urandom_range(0, 3) != 0);
      out_d_opcode = 3'($urandom_range(0, 1));
      out_d_param  = 2'($urandom_range(0, 3));
      out_d_size   = 2'($urandom_range(0, 3));
      out_d_source = SOURCE_W'($urandom_range(0, 1));
      out_d_denied = 1'($urandom_range(0, 1));
      out_d_data   = $urandom;
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
